// File: rtl/bnn_pkg.sv
// Shared types and default sizing for the BNN inference controller.
// The state encoding is common to the controller and any block that decodes its state.
package bnn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      HOLD,
      ERR
   } bnn_ctrl_state_t;

   localparam int unsigned DEF_IMG_SIZE = 30;
   localparam int unsigned DEF_IC       = 1;
   localparam int unsigned DEF_PAD_BITS = 4;
   localparam int unsigned DEF_CLASS_W  = 4;
   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_TIMEOUT  = 4096;

endpackage

// File: rtl/bnn_watchdog.sv
// Run-time watchdog for the BNN core: counts RUN cycles and flags the last permitted cycle.
// Instantiated by bnn_infer_ctrl only when BNN_TIMEOUT_EN is defined.
module bnn_watchdog #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q;

   // expired marks the TIMEOUT-th RUN cycle; the controller leaves RUN on the next edge.
   assign expired = run && (cnt_q == W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (run && !expired) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

endmodule

// File: rtl/bnn_infer_ctrl.sv
// Inference controller: snapshots an unpadded image, pulses core start, holds the class result.
// Define BNN_TIMEOUT_EN to add the RUN watchdog and its ERR state.
module bnn_infer_ctrl
   import bnn_pkg::*;
#(
   parameter int unsigned IMG_SIZE = DEF_IMG_SIZE,
   parameter int unsigned IC       = DEF_IC,
   parameter int unsigned PAD_BITS = DEF_PAD_BITS,
   parameter int unsigned CLASS_W  = DEF_CLASS_W,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [IC*IMG_SIZE*IMG_SIZE+PAD_BITS-1:0] img_in,
   input  logic                                     img_full,
   input  logic                                     bnn_enable,
   input  logic                                     bnn_clear,
   output logic [IC*IMG_SIZE*IMG_SIZE-1:0]          core_img,
   output logic                                     core_start,
   input  logic                                     core_done,
   input  logic [CLASS_W-1:0]                       core_result,
   output logic [CLASS_W-1:0]                       result_out,
   output logic                                     result_ready,
   output logic                                     busy,
   output logic                                     timeout_err,
   output logic [CNT_W-1:0]                         infer_count
);

   localparam int unsigned PIX_W    = IC * IMG_SIZE * IMG_SIZE;
   localparam int unsigned IMG_IN_W = PIX_W + PAD_BITS;

   bnn_ctrl_state_t    state_q, state_d;
   logic [PIX_W-1:0]   core_img_q;
   logic [CLASS_W-1:0] result_q;
   logic               ready_q;
   logic [CNT_W-1:0]   count_q;
   logic               wd_fire;

`ifdef BNN_TIMEOUT_EN
   bnn_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q == LOAD),
      .run     (state_q == RUN),
      .expired (wd_fire)
   );
`else
   localparam int unsigned unused_timeout = TIMEOUT;
   assign wd_fire = 1'b0;
`endif

   if (PAD_BITS > 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^img_in[PAD_BITS-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (img_full && bnn_enable) state_d = LOAD;
         LOAD: state_d = RUN;
         // A completion in the watchdog's final cycle still counts as a result.
         RUN: begin
            if (core_done) begin
               state_d = HOLD;
            end else if (wd_fire) begin
               state_d = ERR;
            end
         end
         HOLD: if (bnn_clear) state_d = IDLE;
         ERR:  if (bnn_clear) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         core_img_q <= '0;
         result_q   <= '0;
         ready_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == LOAD) begin
            core_img_q <= img_in[IMG_IN_W-1:PAD_BITS];
         end
         if (state_q == RUN && core_done) begin
            result_q <= core_result;
            ready_q  <= 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
               count_q <= count_q + CNT_W'(1);
            end
         end
         if (state_q == HOLD && bnn_clear) begin
            ready_q <= 1'b0;
         end
      end
   end

   assign core_img     = core_img_q;
   assign core_start   = (state_q == LOAD);
   assign busy         = (state_q == LOAD) || (state_q == RUN);
   assign result_out   = result_q;
   assign result_ready = ready_q;
   assign infer_count  = count_q;

`ifdef BNN_TIMEOUT_EN
   assign timeout_err = (state_q == ERR);
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed bench for bnn_infer_ctrl: cycle table for the main flow plus corner-case sequences.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_bnn_infer_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [903:0] img_in;
   logic         img_full, bnn_enable, bnn_clear, core_done;
   logic [3:0]   core_result;
   logic [899:0] core_img;
   logic         core_start, result_ready, busy, timeout_err;
   logic [3:0]   result_out;
   logic [15:0]  infer_count;

   bnn_infer_ctrl #(
      .IMG_SIZE (30),
      .IC       (1),
      .PAD_BITS (4),
      .CLASS_W  (4),
      .CNT_W    (16),
      .TIMEOUT  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .img_in       (img_in),
      .img_full     (img_full),
      .bnn_enable   (bnn_enable),
      .bnn_clear    (bnn_clear),
      .core_img     (core_img),
      .core_start   (core_start),
      .core_done    (core_done),
      .core_result  (core_result),
      .result_out   (result_out),
      .result_ready (result_ready),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .infer_count  (infer_count)
   );

   logic [7:0] s_img;
   logic       s_full, s_en, s_clear, s_done;
   logic [3:0] s_res, s_core_img, s_result_out;
   logic       s_start, s_ready, s_busy, s_timeout;
   logic [1:0] s_cnt;

   bnn_infer_ctrl #(
      .IMG_SIZE (2),
      .IC       (1),
      .PAD_BITS (4),
      .CLASS_W  (4),
      .CNT_W    (2),
      .TIMEOUT  (4096)
   ) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .img_in       (s_img),
      .img_full     (s_full),
      .bnn_enable   (s_en),
      .bnn_clear    (s_clear),
      .core_img     (s_core_img),
      .core_start   (s_start),
      .core_done    (s_done),
      .core_result  (s_res),
      .result_out   (s_result_out),
      .result_ready (s_ready),
      .busy         (s_busy),
      .timeout_err  (s_timeout),
      .infer_count  (s_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_img(input string name, input logic [899:0] exp);
      checks++;
      if (core_img !== exp) begin
         errors++;
         $display("FAIL %s: got ..%h expected ..%h", name, core_img[63:0], exp[63:0]);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       full, en, clr, done;
      logic [3:0] res;
      int         img_sel;
      int         exp_img;  // 3 = expect all-zero snapshot
      logic       start, busy, ready;
      logic [3:0] exp_res;
      logic [15:0] cnt;
   } vec_t;

   vec_t         vecs[13];
   logic [903:0] pats[3];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [899:0] e_img;
      int starts, first_start, first_ready, k;

      for (int i = 0; i < 113; i++) begin
         pats[0][i*8 +: 8] = 8'hA5;
         pats[1][i*8 +: 8] = 8'(i) ^ 8'h3C;
         pats[2][i*8 +: 8] = 8'hC3 ^ 8'(i * 7);
      end

      //            full en  clr  done res  img exp start busy rdy  res    cnt
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1, 3, 1'b0, 1'b0, 1'b0, 4'h0, 16'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1, 1'b1, 1'b0, 4'h0, 16'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1, 0, 1'b0, 1'b1, 1'b0, 4'h0, 16'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2, 0, 1'b0, 1'b1, 1'b0, 4'h0, 16'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 1, 0, 1'b0, 1'b0, 1'b1, 4'h7, 16'd1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1, 0, 1'b0, 1'b0, 1'b1, 4'h7, 16'd1};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1, 0, 1'b0, 1'b0, 1'b0, 4'h7, 16'd1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2, 2, 1'b1, 1'b1, 1'b0, 4'h7, 16'd1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 2, 1'b0, 1'b1, 1'b0, 4'h7, 16'd1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 0, 2, 1'b0, 1'b0, 1'b1, 4'hA, 16'd2};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 2, 1'b0, 1'b0, 1'b0, 4'hA, 16'd2};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 0, 2, 1'b0, 1'b0, 1'b0, 4'hA, 16'd2};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1, 2, 1'b0, 1'b0, 1'b0, 4'hA, 16'd2};

      // Reset with every input active: reset must dominate.
      rst = 1'b1;
      img_in = pats[0]; img_full = 1'b1; bnn_enable = 1'b1; bnn_clear = 1'b0;
      core_done = 1'b1; core_result = 4'hF;
      s_img = 8'hB6; s_full = 1'b0; s_en = 1'b1; s_clear = 1'b0; s_done = 1'b0; s_res = 4'h0;
      tick; tick; tick;
      chk_img("reset_core_img", '0);
      chk("reset_start", 64'(core_start), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ready", 64'(result_ready), 64'd0);
      chk("reset_result", 64'(result_out), 64'd0);
      chk("reset_count", 64'(infer_count), 64'd0);
      chk("reset_timeout", 64'(timeout_err), 64'd0);
      img_full = 1'b0; bnn_enable = 1'b0; core_done = 1'b0; core_result = 4'h0;
      rst = 1'b0;

      foreach (vecs[i]) begin
         img_full    = vecs[i].full;
         bnn_enable  = vecs[i].en;
         bnn_clear   = vecs[i].clr;
         core_done   = vecs[i].done;
         core_result = vecs[i].res;
         img_in      = pats[vecs[i].img_sel];
         tick;
         e_img = (vecs[i].exp_img == 3) ? '0 : pats[vecs[i].exp_img][903:4];
         chk_img($sformatf("row%0d_core_img", i), e_img);
         chk($sformatf("row%0d_start", i), 64'(core_start), 64'(vecs[i].start));
         chk($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
         chk($sformatf("row%0d_ready", i), 64'(result_ready), 64'(vecs[i].ready));
         chk($sformatf("row%0d_result", i), 64'(result_out), 64'(vecs[i].exp_res));
         chk($sformatf("row%0d_count", i), 64'(infer_count), 64'(vecs[i].cnt));
         chk($sformatf("row%0d_timeout", i), 64'(timeout_err), 64'd0);
      end
      img_full = 1'b0; bnn_enable = 1'b0; bnn_clear = 1'b0; core_done = 1'b0;

      // Nominal latency: accept at edge 0, done sampled at edge 10 -> ready after edge 10.
      img_in = pats[0]; img_full = 1'b1; bnn_enable = 1'b1;
      starts = 0; first_start = -1; first_ready = -1;
      for (int j = 0; j < 14; j++) begin
         if (j > 0) begin
            img_full = 1'b0; bnn_enable = 1'b0;
            core_done = (j == 10); core_result = 4'h7;
         end
         tick;
         if (core_start) begin
            starts++;
            if (first_start < 0) first_start = j;
         end
         if (result_ready && first_ready < 0) first_ready = j;
      end
      core_done = 1'b0;
      chk("nom_start_pulses", 64'(starts), 64'd1);
      chk("nom_start_edge", 64'(first_start), 64'd0);
      chk("nom_ready_edge", 64'(first_ready), 64'd10);
      chk("nom_result", 64'(result_out), 64'd7);
      chk("nom_count", 64'(infer_count), 64'd3);
      chk_img("nom_core_img", pats[0][903:4]);
      bnn_clear = 1'b1; tick; bnn_clear = 1'b0;
      chk("nom_clear_ready", 64'(result_ready), 64'd0);

      // Reset three cycles into RUN; a late done must be ignored.
      img_full = 1'b1; bnn_enable = 1'b1; tick;
      img_full = 1'b0; bnn_enable = 1'b0; tick;
      tick; tick; tick;
      rst = 1'b1; tick; rst = 1'b0;
      chk("rstrun_busy", 64'(busy), 64'd0);
      chk("rstrun_start", 64'(core_start), 64'd0);
      chk("rstrun_count", 64'(infer_count), 64'd0);
      core_done = 1'b1; core_result = 4'h9; tick; core_done = 1'b0;
      chk("rstrun_late_ready", 64'(result_ready), 64'd0);
      chk("rstrun_late_result", 64'(result_out), 64'd0);
      chk("rstrun_late_count", 64'(infer_count), 64'd0);
      tick;
      chk("rstrun_no_start", 64'(core_start), 64'd0);

`ifdef BNN_TIMEOUT_EN
      img_full = 1'b1; bnn_enable = 1'b1; tick;
      img_full = 1'b0; bnn_enable = 1'b0; tick;
      k = 0;
      while (!timeout_err && k < 40) begin
         tick;
         k++;
      end
      chk("wd_latency", 64'(k), 64'd16);
      chk("wd_ready", 64'(result_ready), 64'd0);
      chk("wd_count", 64'(infer_count), 64'd0);
      chk("wd_busy", 64'(busy), 64'd0);
      bnn_clear = 1'b1; tick; bnn_clear = 1'b0;
      chk("wd_clear_err", 64'(timeout_err), 64'd0);
      chk("wd_clear_busy", 64'(busy), 64'd0);
      // Done in the final permitted cycle: completion wins.
      img_full = 1'b1; bnn_enable = 1'b1; tick;
      img_full = 1'b0; bnn_enable = 1'b0; tick;
      for (int j = 0; j < 15; j++) tick;
      core_done = 1'b1; core_result = 4'h4; tick; core_done = 1'b0;
      chk("wd_race_err", 64'(timeout_err), 64'd0);
      chk("wd_race_ready", 64'(result_ready), 64'd1);
      chk("wd_race_result", 64'(result_out), 64'd4);
      chk("wd_race_count", 64'(infer_count), 64'd1);
      bnn_clear = 1'b1; tick; bnn_clear = 1'b0;
`else
      img_full = 1'b1; bnn_enable = 1'b1; tick;
      img_full = 1'b0; bnn_enable = 1'b0; tick;
      for (int j = 0; j < 40; j++) tick;
      chk("nowd_err", 64'(timeout_err), 64'd0);
      chk("nowd_busy", 64'(busy), 64'd1);
      core_done = 1'b1; core_result = 4'h4; tick; core_done = 1'b0;
      chk("nowd_ready", 64'(result_ready), 64'd1);
      chk("nowd_count", 64'(infer_count), 64'd1);
      bnn_clear = 1'b1; tick; bnn_clear = 1'b0;
`endif

      // Saturating counter on the CNT_W=2 instance.
      for (int i = 0; i < 5; i++) begin
         s_full = 1'b1; tick;
         s_full = 1'b0; tick;
         s_done = 1'b1; s_res = 4'(i); tick;
         s_done = 1'b0;
         chk($sformatf("sat_count%0d", i), 64'(s_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
         s_clear = 1'b1; tick; s_clear = 1'b0;
      end
      chk("sat_core_img", 64'(s_core_img), 64'hB);
      chk("sat_result", 64'(s_result_out), 64'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
